// File: rtl/fsm_rr_arbiter_if.sv
// Handshake bundle between requester agents and the round-robin arbiter.
// The lock input exists only when FSM_RR_ARB_LOCK_EN is defined.
interface fsm_rr_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0] req;
    logic            done;
    logic [NREQ-1:0] gnt;
    logic            busy;
    logic            timeout;
    logic [1:0]      state_o;
`ifdef FSM_RR_ARB_LOCK_EN
    logic            lock;
`endif

    modport master (
        output req,
        output done,
`ifdef FSM_RR_ARB_LOCK_EN
        output lock,
`endif
        input  gnt,
        input  busy,
        input  timeout,
        input  state_o
    );

    modport slave (
        input  req,
        input  done,
`ifdef FSM_RR_ARB_LOCK_EN
        input  lock,
`endif
        output gnt,
        output busy,
        output timeout,
        output state_o
    );
endinterface

// File: rtl/fsm_rr_arbiter.sv
// Four-state round-robin arbiter: one-hot grants, bounded hold, one turnaround cycle between owners.
// Optional FSM_RR_ARB_LOCK_EN adds a lock input that suppresses the hold timeout.
module fsm_rr_arbiter #(
    parameter int NREQ     = 4,
    parameter int MAX_HOLD = 8
) (
    input logic             clk,
    input logic             reset,
    fsm_rr_arbiter_if.slave bus
);
    localparam int PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HCNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(MAX_HOLD - 1);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(NREQ - 1);
    localparam logic [NREQ-1:0]   ONE_HOT0  = NREQ'(1);

    typedef enum logic [1:0] {
        ST_R     = 2'd0,
        ST_IDLE  = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [NREQ-1:0]   gnt_r, gnt_nxt;
    logic [PTR_W-1:0]  ptr, ptr_nxt;
    logic [PTR_W-1:0]  owner, owner_nxt;
    logic [HCNT_W-1:0] hcnt, hcnt_nxt;
    logic              timeout_r, timeout_nxt;
    logic [PTR_W:0]    pick;
    logic              lock_on;
    logic              hold_hit;
    logic              rel_done;
    logic              rel_drop;

    // Returns {found, index} of the first set request scanning ptr, ptr+1, ... modulo NREQ.
    function automatic logic [PTR_W:0] rr_pick(input logic [NREQ-1:0] r,
                                               input logic [PTR_W-1:0] p);
        logic             found;
        logic [PTR_W-1:0] sel;
        logic [PTR_W-1:0] cand;
        int               idx;
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(p) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            cand = PTR_W'(idx);
            if (!found && r[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        return {found, sel};
    endfunction

    function automatic logic [HCNT_W-1:0] hcnt_sat_inc(input logic [HCNT_W-1:0] h);
        return (h == HOLD_LAST) ? h : h + 1'b1;
    endfunction

`ifdef FSM_RR_ARB_LOCK_EN
    assign lock_on = bus.lock;
`else
    assign lock_on = 1'b0;
`endif

    assign pick     = rr_pick(bus.req, ptr);
    assign rel_done = bus.done;
    assign rel_drop = !bus.req[owner];
    assign hold_hit = (hcnt == HOLD_LAST) && !lock_on;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_R;
            gnt_r     <= '0;
            ptr       <= '0;
            owner     <= '0;
            hcnt      <= '0;
            timeout_r <= 1'b0;
        end else begin
            state     <= state_nxt;
            gnt_r     <= gnt_nxt;
            ptr       <= ptr_nxt;
            owner     <= owner_nxt;
            hcnt      <= hcnt_nxt;
            timeout_r <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        gnt_nxt     = gnt_r;
        ptr_nxt     = ptr;
        owner_nxt   = owner;
        hcnt_nxt    = hcnt;
        timeout_nxt = 1'b0;
        case (state)
            ST_R: state_nxt = ST_IDLE;
            ST_IDLE: begin
                if (pick[PTR_W]) begin
                    owner_nxt = pick[PTR_W-1:0];
                    gnt_nxt   = ONE_HOT0 << pick[PTR_W-1:0];
                    hcnt_nxt  = '0;
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (rel_done || rel_drop || hold_hit) begin
                    gnt_nxt     = '0;
                    ptr_nxt     = (owner == PTR_LAST) ? '0 : owner + 1'b1;
                    state_nxt   = ST_DRAIN;
                    // Timeout is flagged only when the hold limit was the sole cause.
                    timeout_nxt = hold_hit && !rel_done && !rel_drop;
                end else begin
                    hcnt_nxt = hcnt_sat_inc(hcnt);
                end
            end
            ST_DRAIN: state_nxt = ST_IDLE;
            default:  state_nxt = ST_R;
        endcase
    end

    assign bus.gnt     = gnt_r;
    assign bus.busy    = |gnt_r;
    assign bus.timeout = timeout_r;
    assign bus.state_o = state;
endmodule

// File: tb/tb_fsm_rr_arbiter.sv
// Bench for fsm_rr_arbiter: directed literal checks plus randomized traffic against a behavioural model.
module tb_fsm_rr_arbiter;
    localparam int NREQ     = 4;
    localparam int MAX_HOLD = 8;
`ifdef FSM_RR_ARB_LOCK_EN
    localparam bit LOCK_BUILD = 1'b1;
`else
    localparam bit LOCK_BUILD = 1'b0;
`endif

    logic            clk   = 1'b0;
    logic            reset = 1'b1;
    logic [NREQ-1:0] req_v  = '0;
    logic            done_v = 1'b0;
    logic            lock_v = 1'b0;

    int tests = 0;
    int fails = 0;

    fsm_rr_arbiter_if #(.NREQ(NREQ)) bus ();

    assign bus.req  = req_v;
    assign bus.done = done_v;
`ifdef FSM_RR_ARB_LOCK_EN
    assign bus.lock = lock_v;
`endif

    fsm_rr_arbiter #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: phase numbers are the documented state codes; m_held counts cycles the grant has been high.
    int   m_phase = 0;
    int   m_owner = 0;
    int   m_ptr   = 0;
    int   m_held  = 0;
    logic m_timeout = 1'b0;

    function automatic logic [NREQ-1:0] model_gnt();
        return (m_phase == 2) ? NREQ'(1 << m_owner) : '0;
    endfunction

    task automatic model_reset();
        m_phase   = 0;
        m_owner   = 0;
        m_ptr     = 0;
        m_held    = 0;
        m_timeout = 1'b0;
    endtask

    task automatic model_step();
        logic lk, by_done, by_drop, by_limit;
        lk = LOCK_BUILD && lock_v;
        m_timeout = 1'b0;
        case (m_phase)
            0: m_phase = 1;
            1: begin
                if (req_v != 0) begin
                    for (int k = 0; k < NREQ; k++) begin
                        int c;
                        c = (m_ptr + k) % NREQ;
                        if (req_v[c]) begin
                            m_owner = c;
                            break;
                        end
                    end
                    m_held  = 1;
                    m_phase = 2;
                end
            end
            2: begin
                by_done  = done_v;
                by_drop  = !req_v[m_owner];
                by_limit = (m_held >= MAX_HOLD) && !lk;
                if (by_done || by_drop || by_limit) begin
                    m_phase   = 3;
                    m_ptr     = (m_owner + 1) % NREQ;
                    m_timeout = by_limit && !by_done && !by_drop;
                end else if (m_held < MAX_HOLD) begin
                    m_held = m_held + 1;
                end
            end
            default: m_phase = 1;
        endcase
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else       model_step();
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            check("cyc_state",   32'(bus.state_o), 32'(m_phase));
            check("cyc_gnt",     32'(bus.gnt),     32'(model_gnt()));
            check("cyc_busy",    32'(bus.busy),    32'(model_gnt() != 0));
            check("cyc_timeout", 32'(bus.timeout), 32'(m_timeout));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    logic [NREQ-1:0] rr_order [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int cnt;
    bit quiet;

    initial begin
        // Reset then idle
        reset = 1'b1;
        step();
        check("rst_state", 32'(bus.state_o), 32'd0);
        check("rst_gnt",   32'(bus.gnt),     32'd0);
        step();
        check("rst_busy",  32'(bus.busy),    32'd0);
        reset = 1'b0;
        step();
        check("idle_state", 32'(bus.state_o), 32'd1);
        step();
        check("idle_hold",  32'(bus.state_o), 32'd1);
        check("idle_gnt",   32'(bus.gnt),     32'd0);

        // Single request with done on third busy cycle
        req_v = 4'b0100;
        step();
        check("single_gnt",   32'(bus.gnt),     32'b0100);
        check("single_st2a",  32'(bus.state_o), 32'd2);
        step();
        check("single_st2b",  32'(bus.state_o), 32'd2);
        step();
        check("single_st2c",  32'(bus.state_o), 32'd2);
        done_v = 1'b1;
        step();
        done_v = 1'b0;
        check("single_drain", 32'(bus.state_o), 32'd3);
        check("single_rel",   32'(bus.gnt),     32'd0);
        step();
        check("single_idle",  32'(bus.state_o), 32'd1);
        req_v = 4'b1111;
        step();
        check("ptr_after_single", 32'(bus.gnt), 32'b1000);

        // Round-robin with all requesting
        done_v = 1'b1;
        step();
        done_v = 1'b0;
        check("rr_drain0", 32'(bus.gnt), 32'd0);
        step();
        step();
        check("rr_wrap", 32'(bus.gnt), 32'b0001);
        for (int i = 0; i < 4; i++) begin
            done_v = 1'b1;
            step();
            done_v = 1'b0;
            check("rr_drain", 32'(bus.state_o), 32'd3);
            step();
            step();
            check("rr_order", 32'(bus.gnt), 32'(rr_order[i]));
        end

        // Hold timeout
        req_v = '0;
        step();
        step();
        req_v = 4'b0001;
        step();
        check("to_gnt", 32'(bus.gnt), 32'b0001);
        cnt = 0;
        while (bus.gnt == 4'b0001 && cnt < 20) begin
            cnt++;
            step();
        end
        check("to_hold_cycles", 32'(cnt),         32'd8);
        check("to_pulse",       32'(bus.timeout), 32'd1);
        check("to_drain",       32'(bus.state_o), 32'd3);
        step();
        check("to_pulse_end",   32'(bus.timeout), 32'd0);
        check("to_idle",        32'(bus.state_o), 32'd1);
        step();
        check("to_regrant",     32'(bus.gnt),     32'b0001);

        // Asynchronous reset mid-grant
        req_v = '0;
        step();
        step();
        req_v = 4'b0010;
        step();
        check("mid_gnt", 32'(bus.gnt), 32'b0010);
        #1 reset = 1'b1;
        #1;
        check("async_gnt",   32'(bus.gnt),     32'd0);
        check("async_state", 32'(bus.state_o), 32'd0);
        check("async_busy",  32'(bus.busy),    32'd0);
        step();
        reset = 1'b0;
        req_v = 4'b1010;
        step();
        check("post_rst_idle", 32'(bus.state_o), 32'd1);
        step();
        check("post_rst_gnt",  32'(bus.gnt),     32'b0010);

`ifdef FSM_RR_ARB_LOCK_EN
        req_v = '0;
        step();
        step();
        req_v  = 4'b0001;
        lock_v = 1'b1;
        step();
        for (int i = 0; i < 20; i++) begin
            check("lock_gnt",     32'(bus.gnt),     32'b0001);
            check("lock_timeout", 32'(bus.timeout), 32'd0);
            step();
        end
        done_v = 1'b1;
        step();
        done_v = 1'b0;
        lock_v = 1'b0;
        check("lock_release", 32'(bus.state_o), 32'd3);
        check("lock_gnt0",    32'(bus.gnt),     32'd0);
`endif

        // Randomized traffic; the per-cycle compare process does the checking
        quiet = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) quiet = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, quiet ? 15 : 3) == 0) req_v = NREQ'($urandom_range(0, 15));
            done_v = ($urandom_range(0, quiet ? 19 : 4) == 0);
            lock_v = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #1 reset = 1'b1;
                #1 reset = 1'b0;
            end
            step();
        end
        req_v  = '0;
        done_v = 1'b0;
        lock_v = 1'b0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
